riscv_if: RTL and testbench

// Instruction-fetch stage; the producer side of the ID stage's i_instr input. Holds the PC and issues word

---
 rtl/riscv_if.sv | 148 ++++++++++++++
 tb/tb_riscv_if.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_if.sv
// Instruction-fetch stage: PC, credit-limited imem request channel and a PC-tagged instruction FIFO.
// Optional feature macro RISCV_IF_MISALIGN_CHK_EN adds o_misalign_err for non-word-aligned redirect targets.
//
// state   | meaning
// S_BOOT  | single idle cycle after reset, no requests
// S_RUN   | issue fetches while outstanding + buffered < FIFO_DEPTH
// S_FLUSH | dropping responses of fetches issued before a redirect
module riscv_if #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc
`ifdef RISCV_IF_MISALIGN_CHK_EN
   ,
   output logic        o_misalign_err
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_q   [FIFO_DEPTH];

   logic [31:0]   redirect_tgt;
   logic          credit_ok;
   logic          req_valid;
   logic          req_fire;
   logic          rsp_live;
   logic          rsp_drop;
   logic          push;
   logic          pop;

   assign redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;

   // In-flight reads are counted against the FIFO so every response has a free slot.
   assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
   assign req_valid = (state_q == S_RUN) && !i_redirect && credit_ok;
   assign req_fire  = req_valid && i_imem_req_ready;
   assign rsp_live  = i_imem_rsp_valid && (outstanding_q != '0);
   assign rsp_drop  = rsp_live && (discard_q != '0);
   assign push      = rsp_live && !rsp_drop && !i_redirect;
   assign pop       = (count_q != '0) && i_instr_ready && !i_redirect;

   assign o_imem_req_valid = req_valid;
   assign o_imem_req_addr  = fetch_pc_q;
   assign o_instr_valid    = (count_q != '0);
   assign o_instr          = fifo_data_q[rd_ptr_q];
   assign o_instr_pc       = fifo_pc_q[rd_ptr_q];

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      discard_d     = discard_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_live);
      if (i_redirect) begin
         fetch_pc_d = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         discard_d  = outstanding_q - CW'(rsp_live);
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         state_d    = (discard_d != '0) ? S_FLUSH : S_RUN;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_drop) discard_d = discard_q - CW'(1);
         if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_FLUSH: if (discard_d == '0) state_d = S_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= S_BOOT;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= i_imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
         end
      end
   end

`ifdef RISCV_IF_MISALIGN_CHK_EN
   logic misalign_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) misalign_q <= 1'b0;
      else       misalign_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
   end

   assign o_misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_riscv_if.sv
// Self-checking bench for riscv_if: directed vector table for the cycle-exact corner cases,
// then random traffic checked against an in-order instruction-stream model and memory queue.
module tb_riscv_if;

   localparam int FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef RISCV_IF_MISALIGN_CHK_EN
   logic        misalign_err;
   logic        s_mis;
`endif

   always #5 clk = ~clk;

   riscv_if #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (req_ready),
      .o_imem_req_addr  (req_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .o_instr          (instr),
      .o_instr_pc       (instr_pc),
      .o_instr_valid    (instr_valid),
      .i_instr_ready    (instr_ready),
`ifdef RISCV_IF_MISALIGN_CHK_EN
      .o_misalign_err   (misalign_err),
`endif
      .i_redirect       (redirect),
      .i_redirect_pc    (redirect_pc)
   );

   typedef struct {
      logic        rst, rr, ir, rd;
      logic [31:0] rpc;
      logic        ren;
      logic        evr;
      logic        ca;
      logic [31:0] ea;
      logic        ev;
      logic        cp;
      logic [31:0] ep;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] mq[$];
   logic [31:0] exp_pc;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_deliv  = 0;

   logic        s_req_valid, s_instr_valid;
   logic [31:0] s_req_addr, s_instr, s_instr_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: drive at negedge, snapshot settled outputs, update memory and stream model.
   task automatic cycle(input logic r, input logic rr, input logic ir, input logic rd,
                        input logic [31:0] rpc, input logic ren);
      rst = r; req_ready = rr; instr_ready = ir; redirect = rd; redirect_pc = rpc;
      if (!r && ren && mq.size() > 0) begin
         rsp_valid = 1'b1;
         rsp_data  = memf(mq.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = $urandom;
      end
      #1;
      s_req_valid = req_valid; s_req_addr = req_addr;
      s_instr_valid = instr_valid; s_instr = instr; s_instr_pc = instr_pc;
`ifdef RISCV_IF_MISALIGN_CHK_EN
      s_mis = misalign_err;
`endif
      if (r) begin
         mq.delete();
         exp_pc = 32'h0;
      end else begin
         if (s_req_valid) chk("req_addr_aligned", {30'h0, s_req_addr[1:0]}, 32'h0);
         if (rd) chk("no_req_on_redirect", s_req_valid, 1'b0);
         if (s_req_valid && rr) begin
            mq.push_back(s_req_addr);
            chk("outstanding_cap", mq.size() <= FIFO_DEPTH, 1'b1);
         end
         if (rd) exp_pc = {rpc[31:2], 2'b00};
         else if (s_instr_valid && ir) begin
            chk("deliver_pc", s_instr_pc, exp_pc);
            chk("deliver_data", s_instr, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
         end
      end
      @(negedge clk);
   endtask

   task automatic add(input logic r, rr, ir, rd, input logic [31:0] rpc, input logic ren,
                      input logic evr, ca, input logic [31:0] ea,
                      input logic ev, cp, input logic [31:0] ep);
      vec_t v;
      v.rst = r; v.rr = rr; v.ir = ir; v.rd = rd; v.rpc = rpc; v.ren = ren;
      v.evr = evr; v.ca = ca; v.ea = ea; v.ev = ev; v.cp = cp; v.ep = ep;
      vecs.push_back(v);
   endtask

   task automatic add_reset();
      add(1, 1, 1, 0, 0, 1,  0, 0, 0,  0, 0, 0);
      add(1, 1, 1, 0, 0, 1,  0, 0, 0,  0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; req_ready = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      redirect_pc = '0; rsp_valid = 1'b0; rsp_data = '0; exp_pc = '0;

      //   rst rr ir rd rpc      ren  evr ca ea        ev cp ep
      // streaming, memory always ready, 1-cycle response
      add_reset();
      add(0, 1, 1, 0, 0,        1,   0, 1, 32'h0,    0, 1, 32'h0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h0,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h4,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h8,    1, 1, 32'h4);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'hC,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h8);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h10,   1, 1, 32'hC);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h14,   0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h10);
      // ID stalled: FIFO fills after two requests, resumes after first pop
      add_reset();
      add(0, 1, 0, 0, 0,        1,   0, 1, 32'h0,    0, 1, 32'h0);
      add(0, 1, 0, 0, 0,        1,   1, 1, 32'h0,    0, 0, 0);
      add(0, 1, 0, 0, 0,        1,   1, 1, 32'h4,    0, 0, 0);
      add(0, 1, 0, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 0, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 0, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 0, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h8,    1, 1, 32'h4);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'hC,    0, 0, 0);
      // redirect with two reads in flight: both stale responses dropped
      add_reset();
      add(0, 1, 1, 0, 0,        0,   0, 1, 32'h0,    0, 1, 32'h0);
      add(0, 1, 1, 0, 0,        0,   1, 1, 32'h0,    0, 0, 0);
      add(0, 1, 1, 0, 0,        0,   1, 1, 32'h4,    0, 0, 0);
      add(0, 1, 1, 1, 32'h100,  0,   0, 0, 0,        0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h100,  0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h104,  0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h100);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h108,  1, 1, 32'h104);
      // redirect coincident with response and pop
      add_reset();
      add(0, 1, 1, 0, 0,        1,   0, 1, 32'h0,    0, 1, 32'h0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h0,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h4,    0, 0, 0);
      add(0, 1, 1, 1, 32'h200,  1,   0, 0, 0,        1, 1, 32'h0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h200,  0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h204,  0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h200);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h208,  1, 1, 32'h204);
      // memory not ready: request held stable
      add_reset();
      add(0, 0, 1, 0, 0,        1,   0, 1, 32'h0,    0, 1, 32'h0);
      for (int k = 0; k < 5; k++)
         add(0, 0, 1, 0, 0,     1,   1, 1, 32'h0,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h0,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   1, 1, 32'h4,    0, 0, 0);
      add(0, 1, 1, 0, 0,        1,   0, 0, 0,        1, 1, 32'h0);

      @(negedge clk);
      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].rr, vecs[i].ir, vecs[i].rd, vecs[i].rpc, vecs[i].ren);
         if (!vecs[i].rst) begin
            chk($sformatf("vec%0d req_valid", i), s_req_valid, vecs[i].evr);
            if (vecs[i].ca) chk($sformatf("vec%0d req_addr", i), s_req_addr, vecs[i].ea);
            chk($sformatf("vec%0d instr_valid", i), s_instr_valid, vecs[i].ev);
            if (vecs[i].cp) begin
               chk($sformatf("vec%0d instr_pc", i), s_instr_pc, vecs[i].ep);
               chk($sformatf("vec%0d instr", i), s_instr, vecs[i].ev ? memf(vecs[i].ep) : 32'h0);
            end
         end
      end

`ifdef RISCV_IF_MISALIGN_CHK_EN
      cycle(1, 1, 1, 0, 0, 1);
      cycle(1, 1, 1, 0, 0, 1);
      cycle(0, 1, 1, 0, 0, 1);
      cycle(0, 1, 1, 1, 32'h102, 1);
      chk("mis_before", s_mis, 1'b0);
      cycle(0, 1, 1, 0, 0, 1);
      chk("mis_pulse", s_mis, 1'b1);
      chk("mis_fetch_addr", s_req_addr, 32'h100);
      cycle(0, 1, 1, 0, 0, 1);
      chk("mis_one_cycle", s_mis, 1'b0);
      cycle(0, 1, 1, 1, 32'h104, 1);
      cycle(0, 1, 1, 0, 0, 1);
      chk("mis_aligned", s_mis, 1'b0);
`endif

      // random traffic
      cycle(1, 1, 1, 0, 0, 1);
      cycle(1, 1, 1, 0, 0, 1);
      n_deliv = 0;
      for (int k = 0; k < 4000; k++) begin
         logic        r, rd;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 599) == 0);
         rd  = ($urandom_range(0, 31) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, rpc,
               $urandom_range(0, 2) != 0);
      end
      chk("liveness", n_deliv >= 300, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
